// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter
//
// Sequencer for the shared 16-bit LC-3 processor bus. Each bus source
// (MARMUX, PC, ALU, MDR, ...) sits behind a tri-state gate. This block
// drives those gate enables so that at most one source drives the bus at
// any time. It also inserts a dead turnaround interval between successive
// owners.
//
// Parameters
//   N_REQ       number of bus sources (2..16)
//   TURNAROUND  all-off cycles between two ownerships (1..7)
//   MAX_HOLD    max consecutive owned cycles when someone else is waiting
//               (0 = unlimited)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          per-source level request
//   gate         registered one-hot-or-zero tri-state enables
//   owner        index of the current owner (0 when the bus is idle)
//   bus_valid    high while any gate bit is high
//   grant_pulse  high during the first cycle of each new ownership
module bus_gate_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gate,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     bus_valid,
  output logic                     grant_pulse
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [HW-1:0]    HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]    HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [TW-1:0]    TURN_LAST = TW'(TURNAROUND - 1);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [TW-1:0]     turn_cnt, turn_nxt;
  logic [OW-1:0]     rr_ptr, rr_nxt;
  logic [N_REQ-1:0]  gate_nxt;
  logic [OW-1:0]     owner_nxt;
  logic              bus_valid_nxt;
  logic              grant_pulse_nxt;

  logic [OW-1:0]     winner;
  int                sel_idx;
  logic              any_req;
  logic              owner_req;
  logic              others_req;
  logic              turn_last;
  logic              grant_now;
  logic              release_now;

  // Round-robin pick. The search starts one past the last winner. The loop
  // walks from the farthest offset down to the nearest, so the nearest set
  // request is written last and wins.
  always_comb begin
    winner  = '0;
    sel_idx = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      sel_idx = int'(rr_ptr) + i;
      if (sel_idx >= N_REQ) sel_idx = sel_idx - N_REQ;
      if ((req & (ONE << sel_idx)) != '0) winner = OW'(sel_idx);
    end
  end

  // Release and grant decisions. While in OWN, gate is exactly
  // onehot(owner), so gate can be used as the owner mask.
  // The hold comparison uses >= rather than ==. When the owner was the sole
  // requester for a long time, hold_cnt has already saturated past
  // MAX_HOLD-1. A late competitor must still force a release.
  always_comb begin
    any_req     = |req;
    owner_req   = |(req & gate);
    others_req  = |(req & ~gate);
    turn_last   = (turn_cnt == TURN_LAST);
    release_now = (state == OWN) &&
                  (!owner_req ||
                   ((MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST) && others_req));
    grant_now   = any_req && ((state == IDLE) || ((state == TURN) && turn_last));
  end

  // State register plus all registered outputs and counters. Reset is
  // asynchronous, so the gates drop without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate        <= '0;
      owner       <= '0;
      bus_valid   <= 1'b0;
      grant_pulse <= 1'b0;
      hold_cnt    <= '0;
      turn_cnt    <= '0;
      rr_ptr      <= OW'(N_REQ - 1);
    end else begin
      state       <= state_nxt;
      gate        <= gate_nxt;
      owner       <= owner_nxt;
      bus_valid   <= bus_valid_nxt;
      grant_pulse <= grant_pulse_nxt;
      hold_cnt    <= hold_nxt;
      turn_cnt    <= turn_nxt;
      rr_ptr      <= rr_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = OWN;
      OWN:  if (release_now) state_nxt = TURN;
      TURN: if (turn_last) state_nxt = any_req ? OWN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and counters. A grant from IDLE
  // and a grant at the end of TURN perform identical actions.
  always_comb begin
    gate_nxt        = gate;
    owner_nxt       = owner;
    bus_valid_nxt   = bus_valid;
    grant_pulse_nxt = 1'b0;
    hold_nxt        = hold_cnt;
    turn_nxt        = turn_cnt;
    rr_nxt          = rr_ptr;

    if (grant_now) begin
      gate_nxt        = ONE << winner;
      owner_nxt       = winner;
      bus_valid_nxt   = 1'b1;
      grant_pulse_nxt = 1'b1;
      hold_nxt        = '0;
      rr_nxt          = winner;
    end else begin
      case (state)
        OWN: begin
          if (release_now) begin
            gate_nxt      = '0;
            owner_nxt     = '0;
            bus_valid_nxt = 1'b0;
            turn_nxt      = '0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        TURN: begin
          gate_nxt      = '0;
          owner_nxt     = '0;
          bus_valid_nxt = 1'b0;
          if (!turn_last) turn_nxt = turn_cnt + 1'b1;
        end
        default: begin
          gate_nxt      = '0;
          owner_nxt     = '0;
          bus_valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Testbench for bus_gate_arbiter. It drives directed sequences and random
// request patterns. Every cycle it compares the DUT outputs with a
// cycle-level behavioural model of the bus ownership rules.
module tb_bus_gate_arbiter;

  localparam int N  = 4;
  localparam int TA = 2;
  localparam int MH = 5;
  localparam int OW = $clog2(N);
  localparam int STARVE_BOUND = N * (MH + TA);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gate;
  logic [OW-1:0] owner;
  logic          bus_valid;
  logic          grant_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. m_owner is -1 when nobody owns the bus.
  // m_held is the number of cycles the current owner has had the gate.
  // m_dead is the number of all-off cycles left in the current turnaround.
  int m_owner;
  int m_held;
  int m_dead;
  int m_ptr;
  int m_pulse;
  int wait_cnt [N];

  always #5 clk = ~clk;

  bus_gate_arbiter #(
    .N_REQ(N),
    .TURNAROUND(TA),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gate(gate),
    .owner(owner),
    .bus_valid(bus_valid),
    .grant_pulse(grant_pulse)
  );

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_owner = -1;
    m_held  = 0;
    m_dead  = 0;
    m_ptr   = N - 1;
    m_pulse = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endfunction

  function automatic int modelPick(input logic [N-1:0] r);
    logic [N-1:0] sh;
    for (int i = 1; i <= N; i++) begin
      int k;
      k  = (m_ptr + i) % N;
      sh = r >> k;
      if (sh[0]) return k;
    end
    return -1;
  endfunction

  // One clock edge of the ownership rules, applied to the request vector
  // sampled at that edge.
  function automatic void modelStep(input logic [N-1:0] r);
    logic [N-1:0] mine;
    int w;
    m_pulse = 0;
    if (m_owner >= 0) begin
      mine = N'(1) << m_owner;
      if (((r & mine) == '0) ||
          ((MH != 0) && (m_held >= MH) && ((r & ~mine) != '0))) begin
        m_owner = -1;
        m_dead  = TA;
      end else begin
        m_held++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      w = modelPick(r);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
        m_ptr   = w;
        m_pulse = 1;
      end
    end
  endfunction

  // Applies one request vector across a rising edge. It advances the model
  // and then compares all outputs. It also checks that a newly granted
  // source did not wait longer than the starvation bound.
  task automatic applyStimulus(input logic [N-1:0] r);
    logic [N-1:0] exp_gate;
    logic [N-1:0] sh_req;
    logic [N-1:0] sh_gate;
    req = r;
    @(posedge clk);
    modelStep(r);
    #1;
    exp_gate = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    checkOutput("gate", 32'(gate), 32'(exp_gate));
    checkOutput("owner", 32'(owner), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    checkOutput("bus_valid", 32'(bus_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    checkOutput("grant_pulse", 32'(grant_pulse), 32'(m_pulse));
    checkOutput("onehot0", 32'($onehot0(gate)), 32'd1);
    if (grant_pulse)
      checkOutput("starve", 32'(wait_cnt[int'(owner)] <= STARVE_BOUND), 32'd1);
    for (int i = 0; i < N; i++) begin
      sh_req  = r >> i;
      sh_gate = gate >> i;
      if (sh_req[0] && !sh_gate[0]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
    end
  endtask

  initial begin
    logic [N-1:0] cur;

    // Reset held low, then released with no requests.
    modelReset();
    req   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gate", 32'(gate), 32'd0);
    checkOutput("rst_valid", 32'(bus_valid), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_pulse", 32'(grant_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) applyStimulus('0);

    // Single grant to source 2, then release.
    applyStimulus(4'b0100);
    checkOutput("single_gate", 32'(gate), 32'h4);
    checkOutput("single_owner", 32'(owner), 32'd2);
    checkOutput("single_pulse", 32'(grant_pulse), 32'd1);
    repeat (3) applyStimulus(4'b0100);
    applyStimulus('0);
    checkOutput("release_gate", 32'(gate), 32'd0);
    repeat (TA + 2) applyStimulus('0);

    // All sources compete: round-robin with forced release.
    repeat (30) applyStimulus(4'b1111);
    repeat (TA + 2) applyStimulus('0);

    // A sole requester keeps the bus, then a late competitor forces release.
    repeat (20) applyStimulus(4'b0001);
    checkOutput("sole_owner", 32'(owner), 32'd0);
    repeat (20) applyStimulus(4'b1001);
    repeat (TA + 2) applyStimulus('0);

    // Asynchronous reset between edges while source 1 owns the bus.
    repeat (2) applyStimulus(4'b0010);
    checkOutput("pre_arst_gate", 32'(gate), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_gate", 32'(gate), 32'd0);
    checkOutput("arst_valid", 32'(bus_valid), 32'd0);
    checkOutput("arst_owner", 32'(owner), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // After reset, index 0 has top priority again.
    applyStimulus(4'b1111);
    checkOutput("post_rst_owner", 32'(owner), 32'd0);

    // Random stress: each request bit toggles with probability 1/8 per cycle.
    cur = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) cur = cur ^ (N'(1) << i);
      applyStimulus(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
